fifo_read_ctrl: RTL and testbench

Read-side controller for the FIFO's 5-bit register-file storage. It generates the one-hot read selects that drive the shared register-file read bus and tracks the read pointer against the write pointer from the write-side controller. It captures each selected word into an output register and presents it downstream with a valid/ready handshake, in first-word fall-through style. It returns its read pointer to the write side so the writer can compute the full condition.

---
 rtl/fifo_read_ctrl_if.sv | 45 ++++
 rtl/fifo_read_ctrl.sv | 99 +++++++++
 tb/tb_fifo_read_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl_if
// Bundles the FIFO read-side signals: the writer's pointer and register-file
// read bus coming in, the one-hot read selects, the returned read pointer and
// the downstream valid/ready output going out.
//   master : the read controller (drives rs, rd_ptr, dout, dout_valid, empty)
//   slave  : the surrounding FIFO / downstream (drives wr_ptr, rd_bus, flush,
//            dout_ready)
// Optional build macro FIFO_RD_LEVEL_EN adds level and almost_empty.
// ---------------------------------------------------------------------------
interface fifo_read_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5,
  parameter int PTR_W = 3
);
  logic [PTR_W:0]   wr_ptr;
  logic [WIDTH-1:0] rd_bus;
  logic             flush;
  logic             dout_ready;
  logic [DEPTH-1:0] rs;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [PTR_W+1:0] level;
  logic             almost_empty;
`endif

  modport master (
    input  wr_ptr, rd_bus, flush, dout_ready,
`ifdef FIFO_RD_LEVEL_EN
    output level, almost_empty,
`endif
    output rs, rd_ptr, dout, dout_valid, empty
  );

  modport slave (
    output wr_ptr, rd_bus, flush, dout_ready,
`ifdef FIFO_RD_LEVEL_EN
    input  level, almost_empty,
`endif
    input  rs, rd_ptr, dout, dout_valid, empty
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl
// Read-side controller for the FIFO register-file storage. Issues a one-hot
// read select for the entry at the read pointer, captures the word into an
// output register and presents it first-word-fall-through with valid/ready.
// The read pointer (with wrap bit) is returned to the writer.
// Ports:
//   clk   : clock, rising edge
//   clear : asynchronous active-low reset
//   bus   : fifo_read_ctrl_if.master (wr_ptr, rd_bus, flush, dout_ready in;
//           rs, rd_ptr, dout, dout_valid, empty out)
// Build option: FIFO_RD_LEVEL_EN adds bus.level and bus.almost_empty.
// ---------------------------------------------------------------------------
module fifo_read_ctrl #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 5,
  parameter int PTR_W     = 3,
  parameter int AE_THRESH = 1
) (
  input logic             clk,
  input logic             clear,
  fifo_read_ctrl_if.master bus
);

  if (DEPTH < 2 || DEPTH != (1 << PTR_W)) begin : g_bad_depth
    $error("fifo_read_ctrl: DEPTH must be a power of two >= 2 equal to 2**PTR_W");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH + 1) begin : g_bad_thresh
    $error("fifo_read_ctrl: AE_THRESH out of range 0..DEPTH+1");
  end

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PTR_W:0]   rd_ptr_q;
  logic [WIDTH-1:0] dout_q;
  logic             empty;
  logic             dout_valid;
  logic             pop;
  logic             fetch;

  // dout_valid is exactly the HOLD state; no separate flag is kept.
  assign dout_valid = (state_q == HOLD);
  assign empty      = (bus.wr_ptr == rd_ptr_q);
  assign pop        = dout_valid & bus.dout_ready;
  // Refill when the holding register is free or being drained this cycle.
  assign fetch      = ~empty & ~bus.flush & (~dout_valid | pop);

  assign bus.rs         = fetch ? (DEPTH'(1) << rd_ptr_q[PTR_W-1:0]) : '0;
  assign bus.rd_ptr     = rd_ptr_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid;
  assign bus.empty      = empty;

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (fetch)        state_d = HOLD;
        HOLD: if (pop & ~fetch) state_d = IDLE;
        default:                state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointer and output word: flush resyncs to the writer and wins over fetch.
  // Natural (PTR_W+1)-bit overflow toggles the wrap bit when the low bits wrap.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else if (bus.flush) begin
      rd_ptr_q <= bus.wr_ptr;
    end else if (fetch) begin
      rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      dout_q   <= bus.rd_bus;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [PTR_W:0] ptr_diff;

  // Modulo pointer difference counts stored words; the held word adds one.
  assign ptr_diff         = bus.wr_ptr - rd_ptr_q;
  assign bus.level        = {1'b0, ptr_diff} + {{(PTR_W+1){1'b0}}, dout_valid};
  assign bus.almost_empty = (bus.level <= (PTR_W+2)'(AE_THRESH));
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;
  localparam int DEPTH = 8;
  localparam int WIDTH = 5;
  localparam int PTR_W = 3;
  localparam int AE_THRESH = 1;

  logic clk = 1'b0;
  logic clear;

  fifo_read_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_W(PTR_W)) ifc ();

  fifo_read_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_W(PTR_W), .AE_THRESH(AE_THRESH)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;

  // Register-file model: written by the bench acting as writer, read via rs.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] bus_word;

  always_comb begin
    bus_word = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ifc.rs[i]) bus_word = mem[i];
  end
  assign ifc.rd_bus = bus_word;

  // Reference model: queue of stored words plus a holding register.
  logic [WIDTH-1:0] q [$];
  bit               m_valid;
  logic [WIDTH-1:0] m_word;
  logic [PTR_W:0]   m_rd;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_word  = '0;
    m_rd    = '0;
  endtask

  // One clock cycle: apply inputs after negedge, check, then advance model.
  task automatic cycle(input bit wr, input logic [WIDTH-1:0] wd, input bit fl, input bit rdy);
    bit emp, pop, fetch;
    logic [DEPTH-1:0] e_rs;
    int lvl;
    ifc.flush      = fl;
    ifc.dout_ready = rdy;
    if (wr && q.size() < DEPTH) begin
      mem[ifc.wr_ptr[PTR_W-1:0]] = wd;
      q.push_back(wd);
      ifc.wr_ptr = ifc.wr_ptr + 1'b1;
    end
    #1;
    emp   = (q.size() == 0);
    pop   = m_valid && rdy;
    fetch = !emp && !fl && (!m_valid || pop);
    e_rs  = '0;
    if (fetch) e_rs[m_rd % DEPTH] = 1'b1;
    check("rs", 32'(ifc.rs), 32'(e_rs));
    check("empty", 32'(ifc.empty), 32'(emp));
    check("rd_ptr", 32'(ifc.rd_ptr), 32'(m_rd));
    check("dout_valid", 32'(ifc.dout_valid), 32'(m_valid));
    check("dout", 32'(ifc.dout), 32'(m_word));
    lvl = q.size() + (m_valid ? 1 : 0);
`ifdef FIFO_RD_LEVEL_EN
    check("level", 32'(ifc.level), 32'(lvl));
    check("almost_empty", 32'(ifc.almost_empty), 32'(lvl <= AE_THRESH));
`endif
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_valid = 1'b0;
      m_rd    = ifc.wr_ptr;
    end else if (fetch) begin
      m_word  = q.pop_front();
      m_valid = 1'b1;
      m_rd    = m_rd + 1'b1;
    end else if (pop) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rs"}, 32'(ifc.rs), 32'd0);
    check({tag, "_rd_ptr"}, 32'(ifc.rd_ptr), 32'd0);
    check({tag, "_dout_valid"}, 32'(ifc.dout_valid), 32'd0);
    check({tag, "_dout"}, 32'(ifc.dout), 32'd0);
    check({tag, "_empty"}, 32'(ifc.empty), 32'd1);
`ifdef FIFO_RD_LEVEL_EN
    check({tag, "_level"}, 32'(ifc.level), 32'd0);
    check({tag, "_almost_empty"}, 32'(ifc.almost_empty), 32'd1);
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    clear          = 1'b0;
    ifc.wr_ptr     = '0;
    ifc.flush      = 1'b0;
    ifc.dout_ready = 1'b0;
    model_reset();
    #2;
    check_reset_state("reset");
    @(negedge clk);
    clear = 1'b1;

    // Single word 0x15 held with downstream stalled, then consumed.
    cycle(1, 5'h15, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);

    // Eight words loaded while stalled, then drained back-to-back.
    for (int i = 1; i <= 8; i++) cycle(1, WIDTH'(i), 0, 0);
    for (int i = 0; i < 11; i++) cycle(0, 0, 0, 1);

    // Walk the pointer across the wrap point with a lagging writer.
    for (int i = 0; i < 12; i++) cycle(1, WIDTH'(5'h10 + i), 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);

    // Flush with three stored and one held while downstream is ready.
    for (int i = 0; i < 4; i++) cycle(1, WIDTH'(5'h0A + i), 0, 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 5'h1F, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);

    // Almost-empty region: 3 stored + 1 held, then drain to 1 held.
    for (int i = 0; i < 4; i++) cycle(1, WIDTH'(5'h03 + i), 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);

    // Randomised traffic with occasional flushes and stalls.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 3) != 0, WIDTH'($urandom), ($urandom % 25) == 0, ($urandom % 4) != 0);
    end
    // Fill-heavy phase.
    for (int i = 0; i < 100; i++) begin
      cycle(($urandom % 4) != 0, WIDTH'($urandom), 1'b0, ($urandom % 4) == 0);
    end

    // Asynchronous reset mid-stream, away from any clock edge.
    for (int i = 0; i < 3; i++) cycle(1, WIDTH'(5'h07 + i), 0, 0);
    #2;
    clear      = 1'b0;
    ifc.wr_ptr = '0;
    ifc.flush  = 1'b0;
    #1;
    check_reset_state("async_clear");
    model_reset();
    @(negedge clk);
    clear = 1'b1;

    for (int i = 0; i < 200; i++) begin
      cycle(($urandom % 2) != 0, WIDTH'($urandom), ($urandom % 40) == 0, ($urandom % 3) != 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
